// File: rtl/dbl_sha_pkg.sv
// Shared constants, FSM state type and beat payload for the double-SHA second-pass streamer.
package dbl_sha_pkg;

  localparam int unsigned BLK_WORDS = 16;
  localparam logic [31:0] PAD_WORD  = 32'h8000_0000;

  typedef enum logic {
    IDLE,
    SEND
  } dbl_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } dbl_beat_t;

  // Message length word placed in the final word of the padded block.
  function automatic logic [31:0] len_word(input int unsigned hash_w);
    return 32'(hash_w);
  endfunction

endpackage

// File: rtl/dbl_sha_stream_if.sv
// Word stream from the digest padder to the shared second-pass SHA core.
interface dbl_sha_stream_if #(
  parameter int unsigned CH_W = 2
);
  logic            dbl_vld;
  logic [31:0]     dbl_din;
  logic [CH_W-1:0] dbl_ch;
  logic            dbl_last;
  logic            dbl_rdy;

  modport master (output dbl_vld, dbl_din, dbl_ch, dbl_last, input dbl_rdy);
  modport slave  (input dbl_vld, dbl_din, dbl_ch, dbl_last, output dbl_rdy);
endinterface

// File: rtl/dbl_sha_rr_arb.sv
// Round-robin arbiter: search starts one past the last granted index, pointer moves on adv.
module dbl_sha_rr_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt_oh_c,
  output logic [IW-1:0] gnt_idx_c,
  output logic          any_c
);

  logic [IW-1:0] ptr_q;
  int unsigned   pos;

  // First requester found walking upward from the pointer, wrapping at N.
  always_comb begin
    gnt_oh_c  = '0;
    gnt_idx_c = '0;
    any_c     = 1'b0;
    pos       = 0;
    for (int unsigned off = 0; off < N; off++) begin
      pos = 32'(ptr_q) + off;
      if (pos >= N) pos = pos - N;
      if (!any_c && req[IW'(pos)]) begin
        any_c               = 1'b1;
        gnt_idx_c           = IW'(pos);
        gnt_oh_c[IW'(pos)]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (adv && any_c) begin
      ptr_q <= (32'(gnt_idx_c) + 32'd1 >= N) ? '0 : gnt_idx_c + IW'(1);
    end
  end

endmodule

// File: rtl/dbl_sha_stream.sv
// Captures first-pass digests from NCH engines and streams each as one padded 512-bit block.
// Build option DBL_SHA_STREAM_BSWAP_EN byte-reverses every digest word on output.
module dbl_sha_stream
  import dbl_sha_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned HASH_W = 256,
  parameter int unsigned CH_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dbl_en,
  input  logic [NCH-1:0]        done,
  input  logic [NCH*HASH_W-1:0] hash,
  dbl_sha_stream_if.master      dbl,
  output logic                  busy,
  output logic [NCH-1:0]        ovf
);

  localparam int unsigned HW    = HASH_W / 32;
  localparam int unsigned CNT_W = $clog2(BLK_WORDS);

  dbl_state_t          state_q, state_nxt;
  dbl_beat_t           beat_q, beat_nxt;
  logic                vld_q, vld_nxt;
  logic [CH_W-1:0]     ch_q, ch_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt, cnt_inc;
  logic [HASH_W-1:0]   sh_q, sh_nxt;
  logic [HASH_W-1:0]   dig_q [NCH];
  logic [NCH-1:0]      pend_q, pend_nxt, ovf_nxt, clr;
  logic [NCH-1:0]      gnt_oh;
  logic [CH_W-1:0]     gnt_idx;
  logic                gnt_any, grant;

  function automatic logic [31:0] bswap(input logic [31:0] w);
`ifdef DBL_SHA_STREAM_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Padded-block word k; dw is the digest word that belongs at k when k is a digest slot.
  function automatic logic [31:0] word_sel(input logic [CNT_W-1:0] k, input logic [31:0] dw);
    if (k < CNT_W'(HW))                  return bswap(dw);
    else if (k == CNT_W'(HW))            return PAD_WORD;
    else if (k == CNT_W'(BLK_WORDS - 1)) return len_word(HASH_W);
    else                                 return '0;
  endfunction

  dbl_sha_rr_arb #(
    .N  (NCH),
    .IW (CH_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (pend_q),
    .adv       (grant),
    .gnt_oh_c  (gnt_oh),
    .gnt_idx_c (gnt_idx),
    .any_c     (gnt_any)
  );

  assign grant   = (state_q == IDLE) && dbl_en && gnt_any;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // A fresh done wins over the grant clear; overwrite of an ungranted digest flags overflow.
  always_comb begin
    clr      = grant ? gnt_oh : '0;
    pend_nxt = (pend_q & ~clr) | done;
    ovf_nxt  = ovf | (done & pend_q & ~clr);
  end

  // Block sequencer: grant loads word 0, each handshake presents the next word.
  always_comb begin
    state_nxt = state_q;
    vld_nxt   = vld_q;
    beat_nxt  = beat_q;
    ch_nxt    = ch_q;
    cnt_nxt   = cnt_q;
    sh_nxt    = sh_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_nxt     = SEND;
          vld_nxt       = 1'b1;
          ch_nxt        = gnt_idx;
          cnt_nxt       = '0;
          sh_nxt        = dig_q[gnt_idx];
          beat_nxt.data = word_sel('0, dig_q[gnt_idx][HASH_W-1 -: 32]);
          beat_nxt.last = 1'b0;
        end
      end
      SEND: begin
        if (vld_q && dbl.dbl_rdy) begin
          if (cnt_q == CNT_W'(BLK_WORDS - 1)) begin
            state_nxt     = IDLE;
            vld_nxt       = 1'b0;
            beat_nxt.last = 1'b0;
          end else begin
            cnt_nxt       = cnt_inc;
            sh_nxt        = sh_q << 32;
            beat_nxt.data = word_sel(cnt_inc, sh_q[HASH_W-33 -: 32]);
            beat_nxt.last = (cnt_inc == CNT_W'(BLK_WORDS - 1));
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      beat_q  <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      pend_q  <= '0;
      ovf     <= '0;
    end else begin
      state_q <= state_nxt;
      vld_q   <= vld_nxt;
      beat_q  <= beat_nxt;
      ch_q    <= ch_nxt;
      cnt_q   <= cnt_nxt;
      busy    <= (state_nxt == SEND);
      pend_q  <= pend_nxt;
      ovf     <= ovf_nxt;
    end
  end

  // Digest storage is data-only and carries no reset.
  always_ff @(posedge clk) begin
    sh_q <= sh_nxt;
    for (int i = 0; i < int'(NCH); i++) begin
      if (done[i]) dig_q[i] <= hash[i*HASH_W +: HASH_W];
    end
  end

  assign dbl.dbl_vld  = vld_q;
  assign dbl.dbl_din  = beat_q.data;
  assign dbl.dbl_last = beat_q.last;
  assign dbl.dbl_ch   = ch_q;

endmodule

// File: tb/tb_dbl_sha_stream.sv
// Directed bench for dbl_sha_stream: block-level expectation queue plus literal spot checks.
module tb_dbl_sha_stream;

  typedef struct {
    int           ch;
    logic [255:0] d;
  } blk_t;

  logic          clk;
  logic          rst_n;
  logic          dbl_en;
  logic [3:0]    done_v;
  logic [1023:0] hash_v;
  logic          busy;
  logic [3:0]    ovf;

  logic          dbl_en224;
  logic [1:0]    done224;
  logic [447:0]  hash224;
  logic          busy224;
  logic [1:0]    ovf224;

  dbl_sha_stream_if #(.CH_W(2)) bus ();
  dbl_sha_stream_if #(.CH_W(1)) bus224 ();

  dbl_sha_stream #(.NCH(4), .HASH_W(256), .CH_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .dbl_en(dbl_en), .done(done_v), .hash(hash_v),
    .dbl(bus), .busy(busy), .ovf(ovf)
  );

  dbl_sha_stream #(.NCH(2), .HASH_W(224), .CH_W(1)) u_dut224 (
    .clk(clk), .rst_n(rst_n), .dbl_en(dbl_en224), .done(done224), .hash(hash224),
    .dbl(bus224), .busy(busy224), .ovf(ovf224)
  );

  int   n_checks = 0;
  int   n_err    = 0;
  int   blocks_done = 0;
  int   n_stall  = 0;
  int   k_cmp    = 0;
  bit   rdy_rand = 0;
  blk_t exp_q[$];

`ifdef DBL_SHA_STREAM_BSWAP_EN
  localparam logic [31:0] W0_LIT  = 32'h0100_0000;
  localparam logic [31:0] W0_224  = 32'h4433_2211;
`else
  localparam logic [31:0] W0_LIT  = 32'h0000_0001;
  localparam logic [31:0] W0_224  = 32'h1122_3344;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] mk_digest(input logic [31:0] seed);
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[255-32*k -: 32] = seed + 32'(k);
    return d;
  endfunction

  function automatic logic [255:0] dig(input logic [31:0] seed, input int i, input bit same);
    return same ? mk_digest(seed) : mk_digest(seed + 32'h100 * 32'(i));
  endfunction

  // Word k of the padded block built from a hw-bit digest held in the low bits of d.
  function automatic logic [31:0] exp_word(input logic [255:0] d, input int k, input int hw);
    logic [31:0] w;
    if (k < hw / 32) begin
      w = d[hw-1-32*k -: 32];
`ifdef DBL_SHA_STREAM_BSWAP_EN
      w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    end else if (k == hw / 32) w = 32'h8000_0000;
    else if (k == 15)          w = 32'(hw);
    else                       w = 32'h0;
    return w;
  endfunction

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic drive_done(input logic [3:0] m, input logic [31:0] seed, input bit same);
    for (int i = 0; i < 4; i++) if (m[i]) hash_v[i*256 +: 256] = dig(seed, i, same);
    done_v = m;
    @(posedge clk); #1;
    done_v = '0;
  endtask

  task automatic push(input int ch, input logic [31:0] seed, input bit same);
    blk_t b;
    b.ch = ch;
    b.d  = dig(seed, ch, same);
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_vld(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.dbl_vld && n < 50) begin @(negedge clk); n++; end
    chk(nm, 64'(bus.dbl_vld), 64'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || k_cmp != 0 || bus.dbl_vld) && n < 2000) begin
      @(negedge clk); n++;
    end
    chk(nm, 64'(n < 2000), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus.dbl_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.dbl_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Per-cycle checker: every handshake against the expected block queue, plus hold and bubble rules.
  blk_t        cur;
  bit          have, prev_stall, last_seen, gap_next;
  logic [31:0] prev_din;
  logic [1:0]  prev_ch;
  logic        prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      k_cmp = 0; have = 0; prev_stall = 0; last_seen = 0; gap_next = 0;
    end else begin
      chk("busy_vs_vld", 64'(busy), 64'(bus.dbl_vld));
      if (gap_next) chk("restart_after_bubble", 64'(bus.dbl_vld), 64'd1);
      gap_next = 0;
      if (last_seen) begin
        chk("bubble_vld", 64'(bus.dbl_vld), 64'd0);
        gap_next = dbl_en && (exp_q.size() > 0);
      end
      last_seen = 0;
      if (prev_stall) begin
        n_stall++;
        chk("hold_vld", 64'(bus.dbl_vld), 64'd1);
        chk("hold_din", 64'(bus.dbl_din), 64'(prev_din));
        chk("hold_ch", 64'(bus.dbl_ch), 64'(prev_ch));
        chk("hold_last", 64'(bus.dbl_last), 64'(prev_last));
      end
      if (bus.dbl_vld && bus.dbl_rdy) begin
        if (k_cmp == 0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_block", 64'd1, 64'd0);
            have = 0;
          end else begin
            cur  = exp_q.pop_front();
            have = 1;
          end
        end
        if (have) begin
          chk("word_ch", 64'(bus.dbl_ch), 64'(cur.ch));
          chk("word_din", 64'(bus.dbl_din), 64'(exp_word(cur.d, k_cmp, 256)));
          chk("word_last", 64'(bus.dbl_last), 64'(k_cmp == 15));
        end
        if (k_cmp == 15) begin
          k_cmp = 0; blocks_done++; last_seen = 1;
        end else begin
          k_cmp++;
        end
      end
      prev_stall = bus.dbl_vld && !bus.dbl_rdy;
      prev_din   = bus.dbl_din;
      prev_ch    = bus.dbl_ch;
      prev_last  = bus.dbl_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int vcount;
    logic [255:0] d224;
    rst_n = 1'b0; dbl_en = 1'b1; done_v = '0; hash_v = '0;
    dbl_en224 = 1'b1; done224 = '0; hash224 = '0; bus224.dbl_rdy = 1'b1;

    // Model pins against hand-computed padding.
    chk("model_w0", 64'(exp_word(mk_digest(32'h1), 0, 256)), 64'(W0_LIT));
    chk("model_w8", 64'(exp_word(mk_digest(32'h1), 8, 256)), 64'h8000_0000);
    chk("model_w15", 64'(exp_word(mk_digest(32'h1), 15, 256)), 64'h100);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", 64'(bus.dbl_vld), 64'd0);
    chk("rst_last", 64'(bus.dbl_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ch", 64'(bus.dbl_ch), 64'd0);
    chk("rst_din", 64'(bus.dbl_din), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_vld224", 64'(bus224.dbl_vld), 64'd0);
    chk("rst_ovf224", 64'(ovf224), 64'd0);
    #1 rst_n = 1'b1;

    // Single digest on channel 2, words 1..8.
    sync();
    b0 = blocks_done;
    push(2, 32'h1, 1);
    drive_done(4'b0100, 32'h1, 1);
    @(negedge clk);
    chk("lat_vld_early", 64'(bus.dbl_vld), 64'd0);
    @(negedge clk);
    chk("lat_vld", 64'(bus.dbl_vld), 64'd1);
    chk("lat_ch", 64'(bus.dbl_ch), 64'd2);
    chk("lat_w0", 64'(bus.dbl_din), 64'(W0_LIT));
    wait_idle("idle_lat");
    chk("lat_blocks", 64'(blocks_done - b0), 64'd1);

    // All four at once, then 1 and 3 together.
    do_reset();
    b0 = blocks_done;
    for (int i = 0; i < 4; i++) push(i, 32'hA000_0000, 0);
    drive_done(4'b1111, 32'hA000_0000, 0);
    wait_idle("idle_all4");
    chk("all4_blocks", 64'(blocks_done - b0), 64'd4);
    sync();
    b0 = blocks_done;
    push(1, 32'hB000_0000, 0);
    push(3, 32'hB000_0000, 0);
    drive_done(4'b1010, 32'hB000_0000, 0);
    wait_idle("idle_13");
    chk("rr13_blocks", 64'(blocks_done - b0), 64'd2);

    // Back-pressure.
    do_reset();
    rdy_rand = 1;
    b0 = blocks_done;
    for (int i = 0; i < 4; i++) push(i, 32'hC000_0000, 0);
    drive_done(4'b1111, 32'hC000_0000, 0);
    wait_idle("idle_rand");
    chk("rand_blocks", 64'(blocks_done - b0), 64'd4);
    chk("rand_saw_stall", 64'(n_stall > 0), 64'd1);
    rdy_rand = 0;

    // Overwrite before grant, then done coincident with grant.
    do_reset();
    dbl_en = 1'b0;
    drive_done(4'b0010, 32'hD100_0000, 1);
    drive_done(4'b0010, 32'hD200_0000, 1);
    @(negedge clk);
    chk("ovf_set", 64'(ovf), 64'h2);
    chk("ovf_no_vld", 64'(bus.dbl_vld), 64'd0);
    b0 = blocks_done;
    push(1, 32'hD200_0000, 1);
    sync();
    dbl_en = 1'b1;
    wait_idle("idle_ovf");
    chk("ovf_blocks", 64'(blocks_done - b0), 64'd1);
    chk("ovf_sticky", 64'(ovf), 64'h2);
    sync();
    b0 = blocks_done;
    push(0, 32'hE100_0000, 1);
    push(0, 32'hE200_0000, 1);
    drive_done(4'b0001, 32'hE100_0000, 1);
    drive_done(4'b0001, 32'hE200_0000, 1);
    wait_idle("idle_coinc");
    chk("coinc_blocks", 64'(blocks_done - b0), 64'd2);
    chk("coinc_no_ovf", 64'(ovf), 64'h2);

    // Reset mid-block at word 6.
    do_reset();
    push(0, 32'hF000_0000, 1);
    drive_done(4'b0001, 32'hF000_0000, 1);
    wait_vld("mid_vld");
    sync();
    drive_done(4'b1000, 32'h5000_0000, 1);
    drive_done(4'b1000, 32'h5100_0000, 1);
    repeat (3) @(posedge clk);
    #2;
    chk("mid_w6", 64'(bus.dbl_din), 64'(exp_word(mk_digest(32'hF000_0000), 6, 256)));
    chk("mid_ovf", 64'(ovf), 64'h8);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 64'(bus.dbl_vld), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ovf", 64'(ovf), 64'd0);
    chk("arst_din", 64'(bus.dbl_din), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    vcount = 0;
    repeat (10) begin @(negedge clk); if (bus.dbl_vld) vcount++; end
    chk("arst_pend_lost", 64'(vcount), 64'd0);
    sync();
    b0 = blocks_done;
    push(2, 32'h7000_0000, 1);
    drive_done(4'b0100, 32'h7000_0000, 1);
    wait_vld("restart_vld");
    chk("restart_w0", 64'(bus.dbl_din), 64'(exp_word(mk_digest(32'h7000_0000), 0, 256)));
    chk("restart_ch", 64'(bus.dbl_ch), 64'd2);
    wait_idle("idle_restart");
    chk("restart_blocks", 64'(blocks_done - b0), 64'd1);

    // 224-bit instance.
    d224 = '0;
    d224[223:192] = 32'h1122_3344;
    for (int k = 1; k < 7; k++) d224[223-32*k -: 32] = 32'(k + 1);
    sync();
    hash224[223:0] = d224[223:0];
    done224 = 2'b01;
    sync();
    done224 = 2'b00;
    vcount = 0;
    @(negedge clk);
    while (!bus224.dbl_vld && vcount < 50) begin @(negedge clk); vcount++; end
    chk("h224_vld", 64'(bus224.dbl_vld), 64'd1);
    chk("h224_w0_lit", 64'(bus224.dbl_din), 64'(W0_224));
    for (int k = 0; k < 16; k++) begin
      chk("h224_din", 64'(bus224.dbl_din), 64'(exp_word(d224, k, 224)));
      chk("h224_last", 64'(bus224.dbl_last), 64'(k == 15));
      chk("h224_ch", 64'(bus224.dbl_ch), 64'd0);
      chk("h224_busy", 64'(busy224), 64'd1);
      if (k == 7)  chk("h224_pad_lit", 64'(bus224.dbl_din), 64'h8000_0000);
      if (k == 15) chk("h224_len_lit", 64'(bus224.dbl_din), 64'hE0);
      @(negedge clk);
    end
    chk("h224_end_vld", 64'(bus224.dbl_vld), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/dbl_sha_stream.md
Name: dbl_sha_stream

Overview:
- Multi-channel, parametrised successor to the double-SHA feedback path.
- Captures first-pass SHA-256/224 digests from NCH hash engines.
- Pads each digest to one 512-bit second-pass block and streams it as 16 x 32-bit words over a valid/ready interface, with channel tag, to the shared second-pass SHA core.
- Sits between the per-miner hash engines and the second SHA core.

Parameters:
- NCH, 4, number of digest source channels (1..8).
- HASH_W, 256, digest width in bits; legal values 224 or 256.
- CH_W, 2, channel-id width; must satisfy 2**CH_W >= NCH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- dbl_en  in  1  level; 0 blocks new grants, but a block already started is completed.
- done  in  NCH  per-channel one-cycle strobe; the matching hash slice is valid.
- hash  in  NCH*HASH_W  digests; channel i is hash[i*HASH_W +: HASH_W].
- dbl_rdy  in  1  downstream accepts the current word.
- dbl_vld  out  1  word valid.
- dbl_din  out  32  current word.
- dbl_ch  out  CH_W  channel of the current block.
- dbl_last  out  1  high on word 15.
- busy  out  1  block in flight.
- ovf  out  NCH  sticky; set when done hits a channel whose pending bit is already set.

Behaviour:
- Reset values:
  - dbl_vld=0, dbl_last=0, busy=0, dbl_ch=0, dbl_din=0, ovf=0.
  - All pending bits 0; round-robin pointer at channel 0; FSM in IDLE.
  - Digest buffers have no reset.
- Capture:
  - done[i] at edge t writes buf[i] and sets pend[i], both visible at t+1.
  - If pend[i] was already set at that edge, the new digest overwrites it and ovf[i] is set (sticky until reset).
- FSM IDLE: if dbl_en and any pend bit set, the round-robin grant picks the lowest index at or above (last granted + 1) mod NCH. Then:
  - buf[g] copied to the shift register;
  - pend[g] cleared;
  - dbl_ch <= g;
  - go to SEND.
- Simultaneous done[g] and grant of g in the same cycle:
  - old buf[g] is loaded;
  - new digest is written;
  - pend[g] stays set (set wins over clear);
  - ovf is not set.
- FSM SEND: dbl_vld=1. A word advances only on dbl_vld&&dbl_rdy. The word counter runs 0..15. Word contents:
  - Words 0..HASH_W/32-1: digest MSB word first.
  - Word HASH_W/32: 32'h8000_0000.
  - Following words: 0.
  - Word 15: HASH_W (32'h0000_0100 or 32'h0000_00E0).
- dbl_vld, dbl_din, dbl_ch and dbl_last are registered and stay stable while dbl_rdy=0.
- Handshake on word 15: return to IDLE, dbl_vld=0 next cycle. The earliest next block begins one cycle later (one idle bubble between blocks).
- busy=1 in SEND.
- Latency: done at edge t, then dbl_vld first high after edge t+2 when idle and granted.
- dbl_en falling mid-block has no effect until the block ends.
- Reset asserted mid-block aborts the block immediately: outputs go to their reset values and pending digests are lost.
- Counter wraps only via the IDLE transition; it never counts past 15.

Optional Feature:
- Macro DBL_SHA_STREAM_BSWAP_EN.
- Defined: every digest word (words 0..HASH_W/32-1) is byte-reversed before output. Padding and length words are unchanged. This is for hash cores that emit little-endian words.
- Undefined: words pass unchanged.
- Timing and handshake are identical in both cases.

Decomposition:
- Package dbl_sha_pkg holds:
  - BLK_WORDS=16;
  - PAD_WORD=32'h8000_0000;
  - the FSM state type (IDLE, SEND);
  - a function giving the word-15 length value from HASH_W.
- One sub-module: dbl_sha_rr_arb, a parametrised NCH-wide round-robin arbiter with request vector, advance strobe, and one-hot plus encoded grant.

Test Plan:
- NCH=4, HASH_W=256, dbl_rdy=1: done[2] with hash=256'h0001..0008 (word k = k+1). Expect:
  - dbl_vld rises 2 cycles later;
  - dbl_ch=2;
  - words 1..8, then 32'h80000000, then six zeros, then 32'h100;
  - dbl_last only on word 16 of the sequence.
- done[0..3] all in one cycle: blocks emitted in channel order 0,1,2,3, with one idle cycle between blocks. Then done[1] and done[3] together: order 1,3 (pointer resumes after 0), then 3,1 is wrong.
- dbl_rdy toggled pseudo-randomly: dbl_din and dbl_ch are held while dbl_rdy=0, and exactly 16 handshakes occur per block.
- Two done[1] strobes before grant (dbl_en=0): ovf[1]=1, only the second digest is streamed, and pend[1] clears after the grant.
- HASH_W=224: 7 digest words, word 7 = 32'h80000000, word 15 = 32'hE0. With DBL_SHA_STREAM_BSWAP_EN, digest word 32'h11223344 outputs 32'h44332211 and padding is unchanged.
- rst_n pulsed low at word 6: dbl_vld drops asynchronously, ovf and pend clear, and the next done restarts cleanly at word 0.
